systolic_array_ctrl: RTL and testbench

Sequencing controller for one `systolic_array` tile computation. It accepts a start request with a reduction length and issues read addresses to the activation and weight buffers. It applies the diagonal input skew the array requires and drives the array's 3-bit operation signal. It then captures the drained results into the output buffer and reports completion with a one-cycle `done` pulse. It sits between the top-level accelerator control (start/done) and the `systolic_array` datapath plus its IBUF/WBUF/OBUF memories.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_array_ctrl_if.sv | 45 ++++
 rtl/systolic_array_ctrl_skew_buffer.sv | 39 +++
 rtl/systolic_array_ctrl.sv | 128 ++++++++++++
 tb/tb_systolic_array_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic tile: PE op codes, controller FSM states and a
// counter-width helper used by the controller and its bus interface.
package systolic_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MAC   = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_OUT   = 3'b100;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StWrite,
        StDone
    } state_e;

    // Width of a counter that must hold 0..limit-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/systolic_array_ctrl_if.sv
// Bus between the tile controller and its environment: start/done handshake, buffer
// read/write ports and the skewed array feed.
interface systolic_array_ctrl_if #(
    parameter int unsigned ARRAY_N   = 8,
    parameter int unsigned ARRAY_M   = 8,
    parameter int unsigned ACT_WIDTH = 8,
    parameter int unsigned WGT_WIDTH = 8,
    parameter int unsigned K_MAX     = 256
);
    localparam int unsigned KW = $clog2(K_MAX);
    localparam int unsigned AW = systolic_pkg::cnt_width(ARRAY_N);

    logic                           start;
    logic [KW:0]                    cfg_k;
    logic                           busy;
    logic                           done;
    logic                           ibuf_rd_en;
    logic [KW-1:0]                  ibuf_rd_addr;
    logic [ARRAY_N*ACT_WIDTH-1:0]   ibuf_rd_data;
    logic                           wbuf_rd_en;
    logic [KW-1:0]                  wbuf_rd_addr;
    logic [ARRAY_M*WGT_WIDTH-1:0]   wbuf_rd_data;
    logic [ARRAY_N*ACT_WIDTH-1:0]   act_data_set_out;
    logic [ARRAY_M*WGT_WIDTH-1:0]   wgt_data_set_out;
    logic [2:0]                     operation_signal_out;
    logic                           obuf_wr_en;
    logic [AW-1:0]                  obuf_wr_addr;

    // Controller side.
    modport master (
        input  start, cfg_k, ibuf_rd_data, wbuf_rd_data,
        output busy, done, ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
               act_data_set_out, wgt_data_set_out, operation_signal_out,
               obuf_wr_en, obuf_wr_addr
    );

    // Accelerator control, buffers and array side.
    modport slave (
        output start, cfg_k, ibuf_rd_data, wbuf_rd_data,
        input  busy, done, ibuf_rd_en, ibuf_rd_addr, wbuf_rd_en, wbuf_rd_addr,
               act_data_set_out, wgt_data_set_out, operation_signal_out,
               obuf_wr_en, obuf_wr_addr
    );

endinterface

// File: rtl/systolic_array_ctrl_skew_buffer.sv
// Diagonal input skew: lane i delays its data and valid bit by i cycles and outputs
// zero whenever its delayed valid bit is low.
module skew_buffer #(
    parameter int unsigned LANES = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   clr_ni,
    input  logic                   valid_i,
    input  logic [LANES*WIDTH-1:0] data_i,
    output logic [LANES*WIDTH-1:0] data_o
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (i == 0) begin : g_pass
            assign data_o[WIDTH-1:0] = valid_i ? data_i[WIDTH-1:0] : '0;
        end else begin : g_dly
            logic [WIDTH-1:0] dat_q [i];
            logic [i-1:0]     vld_q;

            always_ff @(posedge clk) begin
                if (!clr_ni) begin
                    vld_q <= '0;
                    for (int j = 0; j < i; j++) dat_q[j] <= '0;
                end else begin
                    vld_q[0] <= valid_i;
                    dat_q[0] <= data_i[i*WIDTH +: WIDTH];
                    for (int j = 1; j < i; j++) begin
                        vld_q[j] <= vld_q[j-1];
                        dat_q[j] <= dat_q[j-1];
                    end
                end
            end

            assign data_o[i*WIDTH +: WIDTH] = vld_q[i-1] ? dat_q[i-1] : '0;
        end
    end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Tile sequencer: clear, feed k buffer rows through the input skew, drain the array,
// write ARRAY_N result rows to the output buffer, then pulse done.
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int unsigned ARRAY_N      = 8,
    parameter int unsigned ARRAY_M      = 8,
    parameter int unsigned ACT_WIDTH    = 8,
    parameter int unsigned WGT_WIDTH    = 8,
    parameter int unsigned K_MAX        = 256,
    parameter int unsigned DRAIN_CYCLES = 2 * (ARRAY_N + ARRAY_M)
) (
    input logic                  clk,
    input logic                  reset,
    systolic_array_ctrl_if.master bus_io
);

    localparam int unsigned KW = $clog2(K_MAX);
    localparam int unsigned DW = cnt_width(DRAIN_CYCLES);
    localparam int unsigned WW = cnt_width(ARRAY_N);

    state_e        state_q, state_d;
    logic [KW:0]   k_q, k_d;
    logic [KW:0]   feed_cnt_q, feed_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic [WW-1:0] wr_cnt_q, wr_cnt_d;
    logic          rd_vld_q;
    logic [KW:0]   cfg_k_clamped;
    logic          rd_en;
    logic          wr_en;

    assign cfg_k_clamped = (bus_io.cfg_k > (KW+1)'(K_MAX)) ? (KW+1)'(K_MAX) : bus_io.cfg_k;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        feed_cnt_d  = '0;
        drain_cnt_d = '0;
        wr_cnt_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    k_d     = cfg_k_clamped;
                    state_d = (cfg_k_clamped == '0) ? StDone : StClear;
                end
            end
            StClear: state_d = StFeed;
            StFeed: begin
                if (feed_cnt_q == k_q - 1'b1) state_d = StDrain;
                else                          feed_cnt_d = feed_cnt_q + 1'b1;
            end
            StDrain: begin
                if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) state_d = StWrite;
                else                                      drain_cnt_d = drain_cnt_q + 1'b1;
            end
            StWrite: begin
                if (wr_cnt_q == WW'(ARRAY_N - 1)) state_d = StDone;
                else                              wr_cnt_d = wr_cnt_q + 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            k_q         <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            wr_cnt_q    <= '0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_vld_q    <= rd_en;
        end
    end

    // All outputs decode from registered state; addresses are forced to 0 when idle.
    assign rd_en = (state_q == StFeed);
    assign wr_en = (state_q == StWrite);

    always_comb begin
        bus_io.operation_signal_out = OP_NOP;
        unique case (state_q)
            StClear:         bus_io.operation_signal_out = OP_CLEAR;
            StFeed, StDrain: bus_io.operation_signal_out = OP_MAC;
            StWrite:         bus_io.operation_signal_out = OP_OUT;
            default:         bus_io.operation_signal_out = OP_NOP;
        endcase
    end

    assign bus_io.busy         = (state_q != StIdle);
    assign bus_io.done         = (state_q == StDone);
    assign bus_io.ibuf_rd_en   = rd_en;
    assign bus_io.wbuf_rd_en   = rd_en;
    assign bus_io.ibuf_rd_addr = rd_en ? feed_cnt_q[KW-1:0] : '0;
    assign bus_io.wbuf_rd_addr = rd_en ? feed_cnt_q[KW-1:0] : '0;
    assign bus_io.obuf_wr_en   = wr_en;
    assign bus_io.obuf_wr_addr = wr_en ? wr_cnt_q : '0;

    skew_buffer #(
        .LANES (ARRAY_N),
        .WIDTH (ACT_WIDTH)
    ) u_act_skew (
        .clk     (clk),
        .clr_ni  (reset),
        .valid_i (rd_vld_q),
        .data_i  (bus_io.ibuf_rd_data),
        .data_o  (bus_io.act_data_set_out)
    );

    skew_buffer #(
        .LANES (ARRAY_M),
        .WIDTH (WGT_WIDTH)
    ) u_wgt_skew (
        .clk     (clk),
        .clr_ni  (reset),
        .valid_i (rd_vld_q),
        .data_i  (bus_io.wbuf_rd_data),
        .data_o  (bus_io.wgt_data_set_out)
    );

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: a cycle-indexed timing model checked every cycle, plus
// hand-computed literal expectations for the directed scenarios.
module tb_systolic_array_ctrl;
    import systolic_pkg::*;

    localparam int N    = 8;
    localparam int M    = 8;
    localparam int KMAX = 256;
    localparam int D    = 2 * (N + M);

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    systolic_array_ctrl_if #(
        .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(8), .WGT_WIDTH(8), .K_MAX(KMAX)
    ) bus ();

    systolic_array_ctrl #(
        .ARRAY_N(N), .ARRAY_M(M), .ACT_WIDTH(8), .WGT_WIDTH(8), .K_MAX(KMAX),
        .DRAIN_CYCLES(D)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int mode        = 0;

    function automatic logic [7:0] act_fn(input int a, input int n);
        if (mode == 0) return (a == 0) ? 8'hFF : 8'h00;
        return 8'(a * 17 + n * 7 + 1);
    endfunction

    function automatic logic [7:0] wgt_fn(input int a, input int m);
        if (mode == 0) return (a == 0) ? 8'hFF : 8'h00;
        return 8'(((a * 29) ^ (m * 49)) + 3);
    endfunction

    // Buffer memories: 1-cycle read latency, garbage when not enabled.
    always @(posedge clk) begin
        logic [N*8-1:0] ar;
        logic [M*8-1:0] wr;
        for (int n = 0; n < N; n++)
            ar[n*8 +: 8] = bus.ibuf_rd_en ? act_fn(int'(bus.ibuf_rd_addr), n) : 8'hA5;
        for (int m = 0; m < M; m++)
            wr[m*8 +: 8] = bus.wbuf_rd_en ? wgt_fn(int'(bus.wbuf_rd_addr), m) : 8'h5A;
        bus.ibuf_rd_data <= ar;
        bus.wbuf_rd_data <= wr;
    end

    // Model: cycle index since the accepted start, run length and done cycle.
    bit m_active = 1'b0;
    int m_t = 0, m_k = 0, m_done_t = 0;

    always @(posedge clk) begin
        if (!reset) begin
            m_active = 1'b0;
        end else if ((!m_active || m_t > m_done_t) && bus.start) begin
            m_active = 1'b1;
            m_t      = 1;
            m_k      = (int'(bus.cfg_k) > KMAX) ? KMAX : int'(bus.cfg_k);
            m_done_t = (m_k == 0) ? 1 : m_k + 2 + D + N;
        end else if (m_active) begin
            m_t++;
        end
    end

    int done_cnt, done_t_obs, rd_cnt, first_rd_t, last_rd_addr, wr_cnt, first_wr_t;
    logic [2:0] op_t1;
    logic [7:0] act_l7_t10, wgt_l5_t8;

    task automatic clear_obs();
        done_cnt = 0; done_t_obs = -1; rd_cnt = 0; first_rd_t = -1; last_rd_addr = -1;
        wr_cnt = 0; first_wr_t = -1; op_t1 = 3'b111; act_l7_t10 = 8'h11; wgt_l5_t8 = 8'h11;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s (t=%0d): got %h, expected %h", name, m_t, got, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [63:0] e_act, e_wgt;
        logic [2:0]  e_op;
        logic        e_busy, e_done, e_rd, e_wr;
        int          e_addr, e_waddr, a;
        #2;
        e_act = '0; e_wgt = '0; e_op = OP_NOP; e_busy = 0; e_done = 0;
        e_rd = 0; e_wr = 0; e_addr = 0; e_waddr = 0;
        if (m_active) begin
            if (m_k == 0) begin
                e_busy = (m_t == 1);
                e_done = (m_t == 1);
            end else begin
                e_busy = (m_t <= m_done_t);
                e_done = (m_t == m_done_t);
                if (m_t == 1) e_op = OP_CLEAR;
                else if (m_t >= 2 && m_t <= m_k + 1 + D) e_op = OP_MAC;
                else if (m_t >= m_k + 2 + D && m_t < m_done_t) e_op = OP_OUT;
                e_rd    = (m_t >= 2 && m_t <= m_k + 1);
                e_addr  = e_rd ? m_t - 2 : 0;
                e_wr    = (m_t >= m_k + 2 + D && m_t < m_done_t);
                e_waddr = e_wr ? m_t - (m_k + 2 + D) : 0;
                for (int n = 0; n < N; n++) begin
                    a = m_t - 3 - n;
                    if (a >= 0 && a < m_k) e_act[n*8 +: 8] = act_fn(a, n);
                end
                for (int m = 0; m < M; m++) begin
                    a = m_t - 3 - m;
                    if (a >= 0 && a < m_k) e_wgt[m*8 +: 8] = wgt_fn(a, m);
                end
            end
        end
        chk("busy", 64'(bus.busy), 64'(e_busy));
        chk("done", 64'(bus.done), 64'(e_done));
        chk("op", 64'(bus.operation_signal_out), 64'(e_op));
        chk("ibuf_rd_en", 64'(bus.ibuf_rd_en), 64'(e_rd));
        chk("ibuf_rd_addr", 64'(bus.ibuf_rd_addr), 64'(e_addr));
        chk("wbuf_rd_en", 64'(bus.wbuf_rd_en), 64'(e_rd));
        chk("wbuf_rd_addr", 64'(bus.wbuf_rd_addr), 64'(e_addr));
        chk("obuf_wr_en", 64'(bus.obuf_wr_en), 64'(e_wr));
        chk("obuf_wr_addr", 64'(bus.obuf_wr_addr), 64'(e_waddr));
        chk("act_lanes", bus.act_data_set_out, e_act);
        chk("wgt_lanes", bus.wgt_data_set_out, e_wgt);

        if (bus.done) begin done_cnt++; done_t_obs = m_t; end
        if (bus.ibuf_rd_en) begin
            rd_cnt++;
            last_rd_addr = int'(bus.ibuf_rd_addr);
            if (first_rd_t < 0) first_rd_t = m_t;
        end
        if (bus.obuf_wr_en) begin
            wr_cnt++;
            if (first_wr_t < 0) first_wr_t = m_t;
        end
        if (m_active && m_t == 1)  op_t1 = bus.operation_signal_out;
        if (m_active && m_t == 10) act_l7_t10 = bus.act_data_set_out[63:56];
        if (m_active && m_t == 8)  wgt_l5_t8 = bus.wgt_data_set_out[47:40];
    end

    task automatic go(input int k);
        bus.start = 1'b1;
        bus.cfg_k = 9'(k);
        @(negedge clk);
        bus.start = 1'b0;
        bus.cfg_k = '0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.cfg_k = '0;
        clear_obs();
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_op", 64'(bus.operation_signal_out), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // k=4, skew pattern, start pulses at cycles 3 and 46 must be ignored.
        mode = 0;
        clear_obs();
        go(4);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (42) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        chk("k4_done_cnt", 64'(done_cnt), 64'd1);
        chk("k4_done_t", 64'(done_t_obs), 64'd46);
        chk("k4_first_wr", 64'(first_wr_t), 64'd38);
        chk("k4_wr_cnt", 64'(wr_cnt), 64'd8);
        chk("k4_first_rd", 64'(first_rd_t), 64'd2);
        chk("k4_rd_cnt", 64'(rd_cnt), 64'd4);
        chk("k4_op_t1", 64'(op_t1), 64'(3'b010));
        chk("k4_act_l7_t10", 64'(act_l7_t10), 64'hFF);
        chk("k4_wgt_l5_t8", 64'(wgt_l5_t8), 64'hFF);

        // k=0 goes straight to DONE.
        clear_obs();
        go(0);
        repeat (4) @(negedge clk);
        chk("k0_done_cnt", 64'(done_cnt), 64'd1);
        chk("k0_done_t", 64'(done_t_obs), 64'd1);
        chk("k0_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("k0_wr_cnt", 64'(wr_cnt), 64'd0);

        // k=5 with distinct per-lane data.
        mode = 1;
        clear_obs();
        go(5);
        repeat (60) @(negedge clk);
        chk("k5_done_t", 64'(done_t_obs), 64'd47);
        chk("k5_rd_cnt", 64'(rd_cnt), 64'd5);
        chk("k5_act_l7_t10", 64'(act_l7_t10), 64'(8'(7 * 7 + 1)));

        // cfg_k above K_MAX clamps to K_MAX.
        clear_obs();
        go(300);
        repeat (305) @(negedge clk);
        chk("clamp_rd_cnt", 64'(rd_cnt), 64'd256);
        chk("clamp_last_addr", 64'(last_rd_addr), 64'd255);
        chk("clamp_done_t", 64'(done_t_obs), 64'd298);

        // Reset mid-FEED, then a normal run.
        clear_obs();
        go(4);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_op", 64'(bus.operation_signal_out), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_rd_en", 64'(bus.ibuf_rd_en), 64'd0);
        chk("rst_act", bus.act_data_set_out, 64'd0);
        chk("rst_wgt", bus.wgt_data_set_out, 64'd0);
        repeat (60) @(negedge clk);
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        clear_obs();
        go(3);
        repeat (50) @(negedge clk);
        chk("after_rst_done_cnt", 64'(done_cnt), 64'd1);
        chk("after_rst_done_t", 64'(done_t_obs), 64'd45);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
